// File: rtl/matrix_mac_engine_pkg.sv
// matrix_pkg: state encoding, width helpers and memory geometry shared with the loader
package matrix_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, OUTPUT, DONE} state_t;
  localparam int MAT_N = 8;
  localparam int MAT_DATA_WIDTH = 32;
  localparam int MAT_ADDR_WIDTH = $clog2(MAT_N * MAT_N);
  function automatic int addr_w(input int n);
    return $clog2(n * n);
  endfunction
  function automatic int acc_w(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction
endpackage

// File: rtl/matrix_mac_engine_if.sv
// matrix_mac_engine_if: control, A/B memory read ports and result stream of the MAC engine
interface matrix_mac_engine_if import matrix_pkg::*; #(
  parameter int N = MAT_N,
  parameter int DATA_WIDTH = MAT_DATA_WIDTH,
  parameter int ACC_WIDTH = acc_w(DATA_WIDTH, N)
);
  localparam int AW = addr_w(N);
  localparam int IW = $clog2(N);
  logic start;
  logic busy;
  logic done;
  logic [AW-1:0] rd_address_a;
  logic rd_en_a;
  logic signed [DATA_WIDTH-1:0] rd_data_a;
  logic [AW-1:0] rd_address_b;
  logic rd_en_b;
  logic signed [DATA_WIDTH-1:0] rd_data_b;
  logic result_valid;
  logic result_ready;
  logic signed [ACC_WIDTH-1:0] result_data;
  logic [IW-1:0] result_row;
  logic [IW-1:0] result_col;
  modport master (
    input start, rd_data_a, rd_data_b, result_ready,
    output busy, done, rd_address_a, rd_en_a, rd_address_b, rd_en_b,
    output result_valid, result_data, result_row, result_col
  );
  modport slave (
    output start, rd_data_a, rd_data_b, result_ready,
    input busy, done, rd_address_a, rd_en_a, rd_address_b, rd_en_b,
    input result_valid, result_data, result_row, result_col
  );
endinterface

// File: rtl/matrix_mac_engine_mac_pipe.sv
// mac_pipe: registered signed product followed by a sign-extending accumulator
module mac_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH = 2 * DATA_WIDTH + 3
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic first,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [ACC_WIDTH-1:0] acc
);
  localparam int PW = 2 * DATA_WIDTH;
  logic signed [PW-1:0] p;
  logic signed [ACC_WIDTH-1:0] pe;
  logic v, f;
  assign pe = {{(ACC_WIDTH - PW){p[PW-1]}}, p};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      p <= '0;
      v <= 1'b0;
      f <= 1'b0;
      acc <= '0;
    end else begin
      v <= in_valid;
      f <= first;
      if (in_valid) p <= PW'(a) * PW'(b);
      if (v) acc <= f ? pe : acc + pe;
    end
endmodule

// File: rtl/matrix_mac_engine.sv
// matrix_mac_engine: C = A x B from dual-port memories, one N-term signed MAC per element,
// results streamed row-major over valid/ready.
module matrix_mac_engine import matrix_pkg::*; #(
  parameter int N = MAT_N,
  parameter int DATA_WIDTH = MAT_DATA_WIDTH,
  parameter int ACC_WIDTH = acc_w(DATA_WIDTH, N)
) (
  input logic clk,
  input logic rst,
  matrix_mac_engine_if.master m
);
  localparam int AW = addr_w(N);
  localparam int IW = $clog2(N);
  state_t state;
  logic [IW-1:0] i, j, k;
  logic rd_v, rd_first, last_k, last_j, last_el, hs;
  logic signed [ACC_WIDTH-1:0] acc;
  assign last_k = k == IW'(N - 1);
  assign last_j = j == IW'(N - 1);
  assign last_el = last_j && i == IW'(N - 1);
  assign hs = m.result_valid && m.result_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      i <= '0;
      j <= '0;
      k <= '0;
      rd_v <= 1'b0;
      rd_first <= 1'b0;
    end else begin
      rd_v <= state == FETCH;
      rd_first <= state == FETCH && k == '0;
      case (state)
        IDLE: if (m.start) begin
          state <= FETCH;
          i <= '0;
          j <= '0;
          k <= '0;
        end
        FETCH: begin
          k <= last_k ? '0 : k + 1'b1;
          state <= last_k ? DRAIN : FETCH;
        end
        // k doubles as the two-cycle drain counter while the MAC pipeline empties
        DRAIN: begin
          k <= k == IW'(1) ? '0 : k + 1'b1;
          state <= k == IW'(1) ? OUTPUT : DRAIN;
        end
        OUTPUT: if (hs) begin
          state <= last_el ? DONE : FETCH;
          j <= last_j ? '0 : j + 1'b1;
          i <= last_el ? '0 : last_j ? i + 1'b1 : i;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  mac_pipe #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_mac (
    .clk(clk),
    .rst(rst),
    .in_valid(rd_v),
    .first(rd_first),
    .a(m.rd_data_a),
    .b(m.rd_data_b),
    .acc(acc)
  );
  assign m.rd_en_a = state == FETCH;
  assign m.rd_en_b = state == FETCH;
  assign m.rd_address_a = AW'(i * N + k);
  assign m.rd_address_b = AW'(k * N + j);
  assign m.busy = state == FETCH || state == DRAIN || state == OUTPUT;
  assign m.done = state == DONE;
  assign m.result_valid = state == OUTPUT;
  assign m.result_data = acc;
  assign m.result_row = i;
  assign m.result_col = j;
endmodule

// File: tb/tb_matrix_mac_engine.sv
// tb_matrix_mac_engine: scoreboard bench, reference C computed from plain matrix arithmetic
module tb_matrix_mac_engine;
  localparam int N = 2;
  localparam int DW = 32;
  localparam int AW = $clog2(N * N);
  localparam int ACC = 2 * DW + $clog2(N);
  typedef struct {
    logic signed [127:0] data;
    int row;
    int col;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  matrix_mac_engine_if #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(ACC)) bus ();
  matrix_mac_engine #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(ACC)) dut (.clk(clk), .rst(rst), .m(bus));
  exp_t exp_q[$];
  logic signed [DW-1:0] mem_a[N*N];
  logic signed [DW-1:0] mem_b[N*N];
  int checks = 0, errors = 0, cyc = 0;
  int results, dones, rd_cnt, first_v, done_c, s;
  bit stall = 0;
  logic signed [127:0] snap;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.rd_en_a) bus.rd_data_a <= mem_a[bus.rd_address_a];
    if (bus.rd_en_b) bus.rd_data_b <= mem_b[bus.rd_address_b];
  end
  function automatic logic signed [127:0] sx(input logic signed [ACC-1:0] v);
    return v;
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_rd_en"}, {bus.rd_en_a, bus.rd_en_b}, 0);
    chk({tag, "_addr_a"}, bus.rd_address_a, 0);
    chk({tag, "_addr_b"}, bus.rd_address_b, 0);
    chk({tag, "_valid"}, bus.result_valid, 0);
    chk({tag, "_data"}, bus.result_data, 0);
    chk({tag, "_rowcol"}, {bus.result_row, bus.result_col}, 0);
  endtask
  task automatic model();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        exp_t e;
        e.data = 0;
        for (int k = 0; k < N; k++) e.data += 128'(mem_a[i*N+k]) * 128'(mem_b[k*N+j]);
        e.row = i;
        e.col = j;
        exp_q.push_back(e);
      end
  endtask
  always @(negedge clk) if (!rst) begin
    if (bus.rd_en_a) rd_cnt++;
    if (bus.done) dones++;
    if (stall) begin
      chk("stall_data", sx(bus.result_data), snap);
      chk("stall_no_read", {bus.rd_en_a, bus.rd_en_b}, 0);
    end
    if (bus.result_valid && bus.result_ready) begin
      results++;
      if (exp_q.size() == 0) chk("extra_result", 1, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result_data", sx(bus.result_data), e.data);
        chk("result_row", bus.result_row, e.row);
        chk("result_col", bus.result_col, e.col);
      end
    end
  end
  // mode 0: ready held high, 1: random ready, 2: ready low for 10 cycles on the first result
  task automatic run(input int mode, input bit spam, input bit timing);
    int stall_n = 0;
    bit hold;
    logic signed [127:0] c00;
    model();
    c00 = exp_q[0].data;
    results = 0; dones = 0; rd_cnt = 0; first_v = -1; done_c = -1;
    @(posedge clk); #1;
    s = cyc;
    bus.start = 1'b1;
    bus.result_ready = mode != 2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
    for (int c = 0; c < 2000; c++) begin
      if (bus.done) begin
        done_c = cyc;
        chk("busy_at_done", bus.busy, 0);
        break;
      end
      if (bus.result_valid && first_v < 0) first_v = cyc;
      hold = mode == 2 && bus.result_valid && stall_n < 10;
      if (hold && stall_n == 0) snap = sx(bus.result_data);
      stall = hold && stall_n > 0;
      if (hold) stall_n++;
      bus.result_ready = mode == 1 ? 1'($urandom % 2) : !hold;
      bus.start = spam && c % 5 == 2;
      @(posedge clk); #1;
    end
    stall = 0;
    bus.start = 1'b0;
    bus.result_ready = 1'b1;
    chk("done_seen", done_c >= 0, 1);
    if (timing) begin
      chk("first_valid_cycle", first_v, s + N + 3);
      chk("done_cycle", done_c, s + N * N * (N + 3) + 1);
    end
    if (mode == 2) chk("stall_value", snap, c00);
    repeat (3) @(posedge clk);
    #1;
    chk("result_count", results, N * N);
    chk("done_count", dones, 1);
    chk("read_cycles", rd_cnt, N * N * N);
    chk("queue_drained", exp_q.size(), 0);
    chk("idle_busy", bus.busy, 0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.result_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("por");
    rst = 1'b0;
    mem_a = '{1, 2, 3, 4};
    mem_b = '{5, 6, 7, 8};
    run(0, 0, 1);
    mem_a = '{-1, 2, 3, -4};
    mem_b = '{5, -6, -7, 8};
    run(0, 0, 1);
    foreach (mem_a[x]) begin
      mem_a[x] = 32'sh80000000;
      mem_b[x] = 32'sh80000000;
    end
    run(0, 0, 1);
    mem_a = '{1, 2, 3, 4};
    mem_b = '{5, 6, 7, 8};
    run(2, 0, 0);
    foreach (mem_a[x]) begin
      mem_a[x] = $urandom_range(0, 200) - 100;
      mem_b[x] = $urandom_range(0, 200) - 100;
    end
    run(0, 1, 1);
    mem_a = '{1, 2, 3, 4};
    mem_b = '{5, 6, 7, 8};
    model();
    results = 0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 0; c < 100 && results != 1; c++) begin
      @(posedge clk); #1;
    end
    chk("second_fetch_reached", results, 1);
    chk("second_fetch_state", {bus.rd_en_a, bus.rd_en_b, bus.rd_address_b}, {2'b11, AW'(1)});
    rst = 1'b1;
    #1;
    chk_reset("mid_rst");
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    run(0, 0, 1);
    for (int r = 0; r < 4; r++) begin
      foreach (mem_a[x]) begin
        mem_a[x] = $urandom;
        mem_b[x] = $urandom;
      end
      run(1, r % 2, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/matrix_mac_engine.md
# matrix_mac_engine

Consumes matrices A and B once the loader has written them into the dual-port A/B memories, through the memories' read ports, and computes C = A × B. Each C element is computed as a signed multiply-accumulate over N terms. Results leave as a valid/ready stream in row-major order. The block sits directly downstream of the stream-to-memory loader and upstream of whatever drains results (UART, result RAM).

## Interface
Parameters:
- N, 8, matrix dimension. Memories hold N*N words, row-major: A[i][k] at i*N+k, B[k][j] at k*N+j.
- DATA_WIDTH, 32, operand width, two's-complement.
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(N), accumulator and result width.

Ports:
- clk, input, 1, single clock for the whole block.
- rst, input, 1, asynchronous, active-high reset.
- start, input, 1, single-cycle request to multiply; sampled only in IDLE.
- busy, output, 1, high from the cycle after start is accepted until done.
- done, output, 1, one-cycle pulse after the last result handshake.
- rd_address_a, output, $clog2(N*N), A read address.
- rd_en_a, output, 1, A read enable.
- rd_data_a, input, DATA_WIDTH, A data, valid one cycle after the address (registered RAM).
- rd_address_b / rd_en_b / rd_data_b, same as the A read port, for the B memory.
- result_valid, output, 1, result_data holds a completed C element.
- result_ready, input, 1, downstream accepts the result.
- result_data, output, ACC_WIDTH, signed C[i][j].
- result_row, output, $clog2(N), i.
- result_col, output, $clog2(N), j.

## Operation
- FSM states:
  - IDLE: on start, go to FETCH with i=j=k=0.
  - FETCH: drives rd_en_a/b=1 with addresses i*N+k and k*N+j for k=0..N-1, one per cycle. After k=N-1, go to DRAIN.
  - DRAIN: waits 2 cycles for the pipeline to empty, then goes to OUTPUT.
  - OUTPUT: holds result_valid. On result_valid&&result_ready:
    - If (i,j)=(N-1,N-1), go to DONE.
    - Otherwise advance j (wrap to 0 and increment i) and go to FETCH.
  - DONE: pulses done for one cycle, then goes to IDLE.
- MAC pipeline:
  - Stage 1 registers the signed product rd_data_a*rd_data_b (2*DATA_WIDTH).
  - Stage 2 accumulates the sign-extended product into a signed ACC_WIDTH accumulator.
  - The accumulator is cleared (loaded with the product) on the k=0 term.
- ACC_WIDTH guarantees no overflow. The arithmetic is exact signed two's-complement.
- result_data, result_row and result_col are stable while result_valid=1 and ready=0.
- start outside IDLE is ignored.
- No read issued while in OUTPUT. Memory contents are never written by this block.

## Timing
- Reset values: busy=0, done=0, rd_en_a=rd_en_b=0, addresses=0, result_valid=0, result_data=0, result_row=result_col=0, state=IDLE.
- A reset asserted mid-operation aborts immediately with the same values. There is no partial-result output after reset.
- Start sampled in cycle s. Addresses for k=0..N-1 are driven in cycles s+1..s+N. The first result_valid is asserted in cycle s+N+3.
- A handshake in cycle h starts the next fetch in cycle h+1. The next result_valid is asserted at h+N+3.
- With result_ready held at 1, each element takes N+3 cycles. Total start-to-done is N*N*(N+3)+1 cycles.
- done is asserted in the cycle after the final handshake. busy deasserts in that same cycle.
- result_valid falls in the cycle after its handshake.
- rd_en_a and rd_en_b are high exactly N cycles per element.

## Structure
- Package matrix_pkg holds:
  - The state typedef, an enum {IDLE, FETCH, DRAIN, OUTPUT, DONE}.
  - Localparam helpers for address width and ACC_WIDTH.
  - The shared memory-width constants used by the loader.
- Sub-module mac_pipe contains the two-stage multiply/accumulate. Its ports are clk, rst, in_valid, first, a, b and acc.
- The FSM, index counters and output register stay in matrix_mac_engine.

## Test plan
- N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], result_ready=1, start at cycle 0:
  - Results are 19, 22, 43, 50 with (row,col) (0,0), (0,1), (1,0), (1,1).
  - The first result_valid is at cycle 5. done is at cycle 21.
- Signed case, N=2, A=[[-1,2],[3,-4]], B=[[5,-6],[-7,8]] -> C=[[-19,22],[43,-50]].
- Extreme operands, N=4, all entries 0x80000000 -> every result = 4*2^62 = 2^64, exact in 66 bits, no wrap.
- Backpressure, N=2: hold result_ready=0 for 10 cycles on the first result.
  - result_data=19 is stable throughout.
  - No rd_en pulses occur during the stall.
  - Subsequent results are unchanged.
- Start pulsed while busy is ignored. Exactly one done and 4 results are produced.
- Assert rst during FETCH of the second element:
  - All outputs return to their reset values within the reset cycle.
  - A fresh start then yields the full correct sequence from (0,0).
